// File: rtl/dmem_responder.sv
// Word data memory behind a request/response valid-ready pair with a fixed access latency.
// Optional byte-lane store strobes are enabled by defining DMEM_BYTE_STRB_EN.
module dmem_responder #(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
`ifdef DMEM_BYTE_STRB_EN
    input  logic [3:0]  req_wstrb_i,
`endif
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
`ifdef DMEM_BYTE_STRB_EN
    logic [3:0]    wstrb_q, wstrb_d;
`endif

    logic [31:0]   mem_q [DEPTH];

    logic          accept;
    logic          commit;
    logic          acc_write;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_wstrb;
    logic [AW-1:0] acc_idx;
    logic          acc_err;
    logic [31:0]   rd_word;
    logic [31:0]   wr_word;
    logic          mem_we;

    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

    // With LATENCY=1 the access happens on the accept edge, so it must see the live inputs.
    always_comb begin
        accept = req_valid_i && (state_q == IDLE);
        if (state_q == IDLE) begin
            acc_write = req_write_i;
            acc_addr  = req_addr_i;
            acc_wdata = req_wdata_i;
        end else begin
            acc_write = write_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
`ifdef DMEM_BYTE_STRB_EN
        acc_wstrb = (state_q == IDLE) ? req_wstrb_i : wstrb_q;
`else
        acc_wstrb = 4'hF;
`endif
        if (LATENCY == 1) begin
            commit = accept;
        end else begin
            commit = (state_q == WAIT) && (cnt_q == '0);
        end
        acc_idx = acc_addr[2 +: AW];
        acc_err = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= 32'(DEPTH));
        rd_word = mem_q[acc_idx];
        mem_we  = commit && acc_write && !acc_err;
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wr_word[8*gi +: 8] = acc_wstrb[gi] ? acc_wdata[8*gi +: 8] : rd_word[8*gi +: 8];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef DMEM_BYTE_STRB_EN
        wstrb_d     = wstrb_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d = req_write_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
`ifdef DMEM_BYTE_STRB_EN
                    wstrb_d = req_wstrb_i;
`endif
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(LATENCY - 2);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_err || acc_write) ? 32'h0 : rd_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef DMEM_BYTE_STRB_EN
            wstrb_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef DMEM_BYTE_STRB_EN
            wstrb_q     <= wstrb_d;
`endif
        end
    end

    // Per-word registers so that reset can clear the whole array in one edge.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                mem_q[gi] <= '0;
            end else if (mem_we && (acc_idx == AW'(gi))) begin
                mem_q[gi] <= wr_word;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic against a word-array model.
module tb_dmem_responder;
    localparam int DEPTH = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        req_valid1, req_ready1, req_write1;
    logic [31:0] req_addr1, req_wdata1;
    logic [3:0]  req_wstrb1;
    logic        rsp_valid1, rsp_ready1, rsp_err1, busy1;
    logic [31:0] rsp_rdata1;

    int checks = 0;
    int passed = 0;
    logic [31:0] model_mem [DEPTH];

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
`ifdef DMEM_BYTE_STRB_EN
        .req_wstrb_i(req_wstrb),
`endif
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .busy_o(busy)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid1), .req_ready_o(req_ready1), .req_write_i(req_write1),
        .req_addr_i(req_addr1), .req_wdata_i(req_wdata1),
`ifdef DMEM_BYTE_STRB_EN
        .req_wstrb_i(req_wstrb1),
`endif
        .rsp_valid_o(rsp_valid1), .rsp_ready_i(rsp_ready1), .rsp_rdata_o(rsp_rdata1),
        .rsp_err_o(rsp_err1), .busy_o(busy1)
    );

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    endfunction

    // Memory seen as an array of words; strobes pick which bytes of the store data land.
    function automatic void model_apply(input logic w, input logic [31:0] a, input logic [31:0] d,
                                        input logic [3:0] s, output logic [31:0] rd, output logic er);
        logic [31:0] word;
        er = (a % 4 != 0) || (a / 4 >= DEPTH);
        rd = 32'h0;
        if (!er) begin
            if (w) begin
                word = model_mem[a / 4];
                for (int k = 0; k < 4; k++) begin
`ifdef DMEM_BYTE_STRB_EN
                    if (s[k]) word[8*k +: 8] = d[8*k +: 8];
`else
                    if (s[k] || !s[k]) word[8*k +: 8] = d[8*k +: 8];
`endif
                end
                model_mem[a / 4] = word;
            end else begin
                rd = model_mem[a / 4];
            end
        end
    endfunction

    // Drives one transaction on the LATENCY=2 instance; lat counts cycles from accept to rsp_valid.
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int hold, output logic [31:0] rd, output logic er, output int lat);
        int n;
        n = 0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
        rsp_ready = (hold == 0);
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = ~w; req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 50);
        repeat (hold) @(negedge clk);
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        $display("txn w=%0d addr=%h wdata=%h strb=%h rdata=%h err=%0d lat=%0d hold=%0d", w, a, d, s, rd, er, lat, hold);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rsp_valid); else passed++;
        checks++; if (rsp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rsp_rdata); else passed++;
        checks++; if (rsp_err !== 1'b0) $display("FAIL reset_err: got %b want 0", rsp_err); else passed++;
        checks++; if (req_ready1 !== 1'b1) $display("FAIL reset_ready_lat1: got %b want 1", req_ready1); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] rd, exp_rd;
        logic er, exp_er;
        int lat;
        xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
        model_apply(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, exp_rd, exp_er);
        checks++; if (lat !== 2) $display("FAIL store_latency: got %0d want 2", lat); else passed++;
        checks++; if (er !== exp_er) $display("FAIL store_err: got %b want %b", er, exp_er); else passed++;
        checks++; if (rd !== exp_rd) $display("FAIL store_rdata: got %h want %h", rd, exp_rd); else passed++;
        xact(1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er, lat);
        model_apply(1'b0, 32'h10, 32'h0, 4'hF, exp_rd, exp_er);
        checks++; if (lat !== 2) $display("FAIL load_latency: got %0d want 2", lat); else passed++;
        checks++; if (rd !== 32'hDEADBEEF) $display("FAIL load_rdata: got %h want DEADBEEF", rd); else passed++;
        checks++; if (er !== 1'b0) $display("FAIL load_err: got %b want 0", er); else passed++;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_rd, exp_rd2;
        logic exp_er, exp_er2;
        int lat;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wdata = 32'h0; req_wstrb = 4'hF;
        rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) $display("FAIL bp_ready_before: got %b want 1", req_ready); else passed++;
        @(posedge clk); #1;
        req_addr = 32'h20;
        model_apply(1'b0, 32'h10, 32'h0, 4'hF, exp_rd, exp_er);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", i, rsp_valid); else passed++;
            checks++; if (rsp_rdata !== exp_rd) $display("FAIL bp_rdata[%0d]: got %h want %h", i, rsp_rdata, exp_rd); else passed++;
            checks++; if (req_ready !== 1'b0) $display("FAIL bp_ready[%0d]: got %b want 0", i, req_ready); else passed++;
            checks++; if (busy !== 1'b1) $display("FAIL bp_busy[%0d]: got %b want 1", i, busy); else passed++;
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) $display("FAIL bp_ready_after: got %b want 1", req_ready); else passed++;
        checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_valid_after: got %b want 0", rsp_valid); else passed++;
        checks++; if (rsp_rdata !== exp_rd) $display("FAIL bp_rdata_kept: got %h want %h", rsp_rdata, exp_rd); else passed++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        model_apply(1'b0, 32'h20, 32'h0, 4'hF, exp_rd2, exp_er2);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 50);
        checks++; if (lat !== 2) $display("FAIL bp_second_latency: got %0d want 2", lat); else passed++;
        checks++; if (rsp_rdata !== exp_rd2) $display("FAIL bp_second_rdata: got %h want %h", rsp_rdata, exp_rd2); else passed++;
        checks++; if (rsp_err !== exp_er2) $display("FAIL bp_second_err: got %b want %b", rsp_err, exp_er2); else passed++;
        @(posedge clk); #1;
        $display("txn backpressure load 0x10 then load 0x20 rdata=%h", exp_rd2);
    endtask

    task automatic test_errors();
        logic [31:0] rd, exp_rd;
        logic er, exp_er;
        int lat;
        xact(1'b1, 32'h13, 32'h12345678, 4'hF, 1, rd, er, lat);
        model_apply(1'b1, 32'h13, 32'h12345678, 4'hF, exp_rd, exp_er);
        checks++; if (er !== 1'b1) $display("FAIL misalign_err: got %b want 1", er); else passed++;
        checks++; if (rd !== exp_rd) $display("FAIL misalign_rdata: got %h want %h", rd, exp_rd); else passed++;
        xact(1'b1, 32'h200, 32'h12345678, 4'hF, 0, rd, er, lat);
        checks++; if (er !== 1'b1) $display("FAIL range_err: got %b want 1", er); else passed++;
        xact(1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEEF) $display("FAIL after_err_rdata: got %h want DEADBEEF", rd); else passed++;
        checks++; if (er !== 1'b0) $display("FAIL after_err_err: got %b want 0", er); else passed++;
        xact(1'b0, 32'h0, 32'h0, 4'hF, 0, rd, er, lat);
        model_apply(1'b0, 32'h0, 32'h0, 4'hF, exp_rd, exp_er);
        checks++; if (rd !== exp_rd) $display("FAIL alias_word0: got %h want %h", rd, exp_rd); else passed++;
    endtask

    task automatic test_strobe();
        logic [31:0] rd, exp_rd, want;
        logic er, exp_er;
        int lat;
`ifdef DMEM_BYTE_STRB_EN
        want = 32'h1122CC44;
`else
        want = 32'hAABBCCDD;
`endif
        xact(1'b1, 32'h40, 32'h11223344, 4'hF, 0, rd, er, lat);
        model_apply(1'b1, 32'h40, 32'h11223344, 4'hF, exp_rd, exp_er);
        xact(1'b1, 32'h40, 32'hAABBCCDD, 4'h2, 0, rd, er, lat);
        model_apply(1'b1, 32'h40, 32'hAABBCCDD, 4'h2, exp_rd, exp_er);
        xact(1'b0, 32'h40, 32'h0, 4'hF, 0, rd, er, lat);
        checks++; if (rd !== want) $display("FAIL strobe_merge: got %h want %h", rd, want); else passed++;
        xact(1'b1, 32'h44, 32'h99999999, 4'h0, 0, rd, er, lat);
        model_apply(1'b1, 32'h44, 32'h99999999, 4'h0, exp_rd, exp_er);
        checks++; if (er !== 1'b0) $display("FAIL strobe_zero_err: got %b want 0", er); else passed++;
        xact(1'b0, 32'h44, 32'h0, 4'hF, 0, rd, er, lat);
        model_apply(1'b0, 32'h44, 32'h0, 4'hF, exp_rd, exp_er);
        checks++; if (rd !== exp_rd) $display("FAIL strobe_zero_data: got %h want %h", rd, exp_rd); else passed++;
    endtask

    task automatic test_reset_midflight();
        logic [31:0] rd;
        logic er;
        int lat;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h55; req_wstrb = 4'hF;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b0) $display("FAIL midrst_valid[%0d]: got %b want 0", i, rsp_valid); else passed++;
            checks++; if (req_ready !== 1'b1) $display("FAIL midrst_ready[%0d]: got %b want 1", i, req_ready); else passed++;
        end
        @(posedge clk); #1;
        xact(1'b0, 32'h20, 32'h0, 4'hF, 0, rd, er, lat);
        checks++; if (rd !== 32'h0) $display("FAIL midrst_load: got %h want 00000000", rd); else passed++;
        xact(1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er, lat);
        checks++; if (rd !== 32'h0) $display("FAIL midrst_cleared: got %h want 00000000", rd); else passed++;
    endtask

    task automatic test_latency1();
        logic [31:0] ad [4];
        logic [31:0] wd [4];
        logic [31:0] exp [4];
        logic        wr [4];
        wd[0] = $urandom; wd[1] = $urandom; wd[2] = 32'h0; wd[3] = 32'h0;
        ad[0] = 32'h0; ad[1] = 32'h4; ad[2] = 32'h0; ad[3] = 32'h4;
        wr[0] = 1'b1; wr[1] = 1'b1; wr[2] = 1'b0; wr[3] = 1'b0;
        exp[0] = 32'h0; exp[1] = 32'h0; exp[2] = wd[0]; exp[3] = wd[1];
        req_valid1 = 1'b1; rsp_ready1 = 1'b1; req_wstrb1 = 4'hF;
        for (int k = 0; k < 4; k++) begin
            req_write1 = wr[k]; req_addr1 = ad[k]; req_wdata1 = wd[k];
            @(negedge clk);
            checks++; if (req_ready1 !== 1'b1) $display("FAIL lat1_ready[%0d]: got %b want 1", k, req_ready1); else passed++;
            checks++; if (rsp_valid1 !== 1'b0) $display("FAIL lat1_idle_valid[%0d]: got %b want 0", k, rsp_valid1); else passed++;
            @(posedge clk); #1;
            // A store kept on the bus during the response edge must be ignored.
            req_write1 = 1'b1; req_addr1 = 32'h0; req_wdata1 = 32'hBAD0BAD0;
            if (k == 3) req_valid1 = 1'b0;
            @(negedge clk);
            checks++; if (rsp_valid1 !== 1'b1) $display("FAIL lat1_valid[%0d]: got %b want 1", k, rsp_valid1); else passed++;
            checks++; if (rsp_rdata1 !== exp[k]) $display("FAIL lat1_rdata[%0d]: got %h want %h", k, rsp_rdata1, exp[k]); else passed++;
            checks++; if (req_ready1 !== 1'b0) $display("FAIL lat1_busy[%0d]: got %b want 0", k, req_ready1); else passed++;
            @(posedge clk); #1;
            $display("txn lat1 w=%0d addr=%h rdata=%h", wr[k], ad[k], exp[k]);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d, rd, exp_rd;
        logic [3:0]  s;
        logic        w, er, exp_er;
        int          lat, hold;
        for (int i = 0; i < 80; i++) begin
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: a = $urandom;
                1: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
                2: a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
                default: a = 32'($urandom_range(0, 15)) << 2;
            endcase
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            hold = $urandom_range(0, 3);
            xact(w, a, d, s, hold, rd, er, lat);
            model_apply(w, a, d, s, exp_rd, exp_er);
            checks++; if (lat !== 2) $display("FAIL rnd_latency[%0d]: got %0d want 2", i, lat); else passed++;
            checks++; if (er !== exp_er) $display("FAIL rnd_err[%0d]: got %b want %b addr=%h", i, er, exp_er, a); else passed++;
            checks++; if (rd !== exp_rd) $display("FAIL rnd_rdata[%0d]: got %h want %h addr=%h", i, rd, exp_rd, a); else passed++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = 4'hF; rsp_ready = 1'b1;
        req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_wstrb1 = 4'hF; rsp_ready1 = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_errors();
        test_strobe();
        test_reset_midflight();
        test_latency1();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
